v810_exseq: RTL and testbench
=============================

V810_EXSEQ -- requirements
Module: v810_exseq

Interface
REQ-001 SHALL have ports: CLK in 1, sole clock; RES in 1, synchronous active-high reset; CE in 1, global clock enable.
REQ-002 SHALL have ports: PSW in psw_t, current PSW; PC in 32, restart PC supplied by EU; BOUND in 1, EU at instruction boundary; RETI in 1, EU executing RETI.
REQ-003 SHALL have ports from/to interrupt mux: IF in 1; NP in 1; IEL in 4; CC in 16; HA in 32; ACK out 1.
REQ-004 SHALL have outputs: PC_LD 1, PC_OUT 32, PSW_LD 1, PSW_OUT psw_t, EIPC 32, EIPSW 32, FEPC 32, FEPSW 32, ECR 32 ({FECC,EICC}), BUSY 1, FATAL 1.
REQ-005 SHALL use one clock; reset SHALL be synchronous and active-high, port RES; all state SHALL advance only when CE=1.

Function
REQ-006 SHALL implement states IDLE, TAKE, VEC, HALT.
REQ-007 IDLE: RETI=1 SHALL take priority over IF; otherwise IF=1 & BOUND=1 SHALL go to TAKE; else stay.
REQ-008 RETI in IDLE, single cycle: PC_LD=PSW_LD=1; PSW.np=1 -> PC_OUT=FEPC, PSW_OUT=FEPSW; else PC_OUT=EIPC, PSW_OUT=EIPSW; stays IDLE.
REQ-009 TAKE: ACK=1 for exactly one CE cycle; SHALL latch PC and PSW into entry copies; next state VEC.
REQ-010 VEC: NP, CC, IEL, HA (registered in mux on TAKE edge) SHALL be sampled this cycle, not in TAKE.
REQ-011 VEC, NP=0: EIPC<=PC copy, EIPSW<=PSW copy, ECR[15:0]<=CC; PSW_OUT = copy with ep=1, id=1, ae=0, i=IEL if IEL!=0 else unchanged.
REQ-012 VEC, NP=1: FEPC<=PC copy, FEPSW<=PSW copy, ECR[31:16]<=CC; PSW_OUT = copy with np=1, id=1, ae=0.
REQ-013 VEC, CC=16'hFFF0 (reset): PSW_OUT=32'h0000_8000, ECR<=32'h0000_FFF0, EIPC/FEPC unchanged; PC_OUT=HA.
REQ-014 VEC, non-fatal: PC_LD=PSW_LD=1, PC_OUT=HA; next state IDLE.
REQ-015 BUSY=1 in TAKE, VEC, HALT; 0 in IDLE.
REQ-016 PC_LD, PSW_LD, ACK SHALL be single-cycle pulses, 0 otherwise; PC_OUT/PSW_OUT don't-care when their load is 0.
REQ-017 IF dropping during TAKE SHALL not abort; VEC proceeds with mux outputs.
REQ-018 BOUND=0 SHALL hold IDLE with IF pending; no ACK.

Reset
REQ-019 RES=1 (CE-qualified) SHALL force IDLE, ACK=0, PC_LD=0, PSW_LD=0, FATAL=0, BUSY=0.
REQ-020 RES SHALL clear EIPC, FEPC, ECR to 0, EIPSW and FEPSW to 0, entry copies to 0.
REQ-021 RES asserted in TAKE, VEC or HALT SHALL abandon the sequence; no register write that cycle.

Configuration
REQ-022 Macro V810_FATAL_EN SHALL enable fatal-exception detection.
REQ-023 Defined: VEC with PSW copy np=1 and CC!=16'hFFF0 SHALL enter HALT, FATAL=1, no PC/PSW/EIPC/FEPC/ECR writes; HALT is left only by RES.
REQ-024 Undefined: same case SHALL follow REQ-012 (FEPC/FEPSW overwritten); FATAL tied 0; HALT unreachable.

Verification
REQ-025 IF=1, NP=0, CC=FE30, IEL=4, HA=FFFF_FE30, PC=0000_1000, PSW=0, BOUND=1 -> ACK one cycle; next cycle PC_OUT=FFFF_FE30, EIPC=0000_1000, ECR[15:0]=FE30, PSW_OUT.i=4, ep=1, id=1.
REQ-026 IF=1, NP=1, CC=FFD0, HA=FFFF_FFD0, PC=0000_2000 -> FEPC=0000_2000, ECR[31:16]=FFD0, PSW_OUT.np=1.
REQ-027 After REQ-025, RETI=1 with PSW.np=0 -> PC_OUT=0000_1000, PSW_OUT=0, same cycle; RETI and IF same cycle -> RETI serviced, ACK next-later.
REQ-028 With V810_FATAL_EN: PSW.np=1, IF=1, CC=FF90 -> FATAL=1, BUSY=1, no loads, until RES; without macro -> FEPC written, FATAL=0.
REQ-029 IF=1, BOUND=0 for 5 cycles -> ACK=0; RES pulsed in VEC -> IDLE, no PC_LD, registers 0.
REQ-030 CE toggling 1/0 during sequence -> identical results, pulses stretched only across CE=0 cycles.

Source files
------------

// File: rtl/v810_exseq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : v810_exseq
// Purpose  : V810 exception entry / RETI sequencer. Takes an interrupt or
//            exception at an instruction boundary, saves the restart PC and
//            PSW into the EI or FE save registers, and loads the handler
//            address plus the new PSW into the execution unit. It also
//            services RETI by reloading PC/PSW from the matching save pair.
//
// Ports    : CLK, RES (sync, active-high), CE (global clock enable)
//            PSW[31:0]   current PSW       PC[31:0]   restart PC from EU
//            BOUND       EU at boundary    RETI       EU executing RETI
//            IF, NP, IEL[3:0], CC[15:0], HA[31:0]  from interrupt mux
//            ACK         to interrupt mux (one-cycle pulse in TAKE)
//            PC_LD/PC_OUT, PSW_LD/PSW_OUT   load requests to EU
//            EIPC, EIPSW, FEPC, FEPSW, ECR  architectural save registers
//            BUSY (sequence in flight), FATAL (halted on fatal exception)
//
// Timing   : every output is registered. A load pulse (PC_LD/PSW_LD) is
//            visible in the cycle after the IDLE(RETI) or VEC state that
//            produced it. All state, reset included, advances only on CE=1.
//
// Config   : V810_FATAL_EN - when defined, an exception taken while the
//            saved PSW already has NP set (other than the reset vector)
//            parks the sequencer in HALT with FATAL=1 until RES.
//
// Revision : 1.0 - initial release
// ============================================================================
module v810_exseq (
    input  logic        CLK,
    input  logic        RES,
    input  logic        CE,
    input  logic [31:0] PSW,
    input  logic [31:0] PC,
    input  logic        BOUND,
    input  logic        RETI,
    input  logic        IF,
    input  logic        NP,
    input  logic [3:0]  IEL,
    input  logic [15:0] CC,
    input  logic [31:0] HA,
    output logic        ACK,
    output logic        PC_LD,
    output logic [31:0] PC_OUT,
    output logic        PSW_LD,
    output logic [31:0] PSW_OUT,
    output logic [31:0] EIPC,
    output logic [31:0] EIPSW,
    output logic [31:0] FEPC,
    output logic [31:0] FEPSW,
    output logic [31:0] ECR,
    output logic        BUSY,
    output logic        FATAL
);

    localparam logic [1:0]  c_ST_IDLE   = 2'd0;
    localparam logic [1:0]  c_ST_TAKE   = 2'd1;
    localparam logic [1:0]  c_ST_VEC    = 2'd2;
    localparam logic [1:0]  c_ST_HALT   = 2'd3;

    // PSW bit positions
    localparam int          c_PSW_ID    = 12;
    localparam int          c_PSW_AE    = 13;
    localparam int          c_PSW_EP    = 14;
    localparam int          c_PSW_NP    = 15;

    localparam logic [15:0] c_CC_RESET  = 16'hFFF0;
    localparam logic [31:0] c_PSW_RESET = 32'h0000_8000;

    logic [1:0]  r_state;
    logic [31:0] r_pc_cpy;
    logic [31:0] r_psw_cpy;

    logic        w_reset_vec;
    logic        w_fatal;
    logic        w_use_fe;
    logic [31:0] w_psw_ei;
    logic [31:0] w_psw_fe;

    assign w_reset_vec = (CC == c_CC_RESET);

`ifdef V810_FATAL_EN
    // A second exception while still inside an NP handler cannot be saved
    // without destroying FEPC/FEPSW, so it is treated as fatal.
    assign w_fatal  = r_psw_cpy[c_PSW_NP] & ~w_reset_vec;
    assign w_use_fe = NP;
`else
    // Without fatal detection a nested NP exception simply overwrites the
    // FE save pair.
    assign w_fatal  = 1'b0;
    assign w_use_fe = NP | r_psw_cpy[c_PSW_NP];
`endif

    // Handler PSW images derived from the PSW captured at entry.
    always_comb begin
        w_psw_ei           = r_psw_cpy;
        w_psw_ei[c_PSW_EP] = 1'b1;
        w_psw_ei[c_PSW_ID] = 1'b1;
        w_psw_ei[c_PSW_AE] = 1'b0;
        if (IEL != 4'd0) begin
            w_psw_ei[19:16] = IEL;
        end

        w_psw_fe           = r_psw_cpy;
        w_psw_fe[c_PSW_NP] = 1'b1;
        w_psw_fe[c_PSW_ID] = 1'b1;
        w_psw_fe[c_PSW_AE] = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (CE) begin
            if (RES) begin
                r_state   <= c_ST_IDLE;
                r_pc_cpy  <= '0;
                r_psw_cpy <= '0;
                ACK       <= 1'b0;
                PC_LD     <= 1'b0;
                PC_OUT    <= '0;
                PSW_LD    <= 1'b0;
                PSW_OUT   <= '0;
                EIPC      <= '0;
                EIPSW     <= '0;
                FEPC      <= '0;
                FEPSW     <= '0;
                ECR       <= '0;
                BUSY      <= 1'b0;
                FATAL     <= 1'b0;
            end else begin
                // Pulses last exactly one enabled cycle.
                ACK    <= 1'b0;
                PC_LD  <= 1'b0;
                PSW_LD <= 1'b0;

                case (r_state)
                    c_ST_IDLE: begin
                        if (RETI) begin
                            // RETI wins over a pending interrupt; the
                            // interrupt is taken on a later boundary.
                            PC_LD  <= 1'b1;
                            PSW_LD <= 1'b1;
                            if (PSW[c_PSW_NP]) begin
                                PC_OUT  <= FEPC;
                                PSW_OUT <= FEPSW;
                            end else begin
                                PC_OUT  <= EIPC;
                                PSW_OUT <= EIPSW;
                            end
                        end else if (IF && BOUND) begin
                            r_state <= c_ST_TAKE;
                            ACK     <= 1'b1;
                            BUSY    <= 1'b1;
                        end
                    end

                    c_ST_TAKE: begin
                        // The mux registers NP/CC/IEL/HA on this same edge,
                        // so they are only consumed in VEC.
                        r_pc_cpy  <= PC;
                        r_psw_cpy <= PSW;
                        r_state   <= c_ST_VEC;
                    end

                    c_ST_VEC: begin
                        if (w_reset_vec) begin
                            PC_LD   <= 1'b1;
                            PSW_LD  <= 1'b1;
                            PC_OUT  <= HA;
                            PSW_OUT <= c_PSW_RESET;
                            ECR     <= {16'h0000, c_CC_RESET};
                            r_state <= c_ST_IDLE;
                            BUSY    <= 1'b0;
                        end else if (w_fatal) begin
                            r_state <= c_ST_HALT;
                            FATAL   <= 1'b1;
                        end else begin
                            PC_LD   <= 1'b1;
                            PSW_LD  <= 1'b1;
                            PC_OUT  <= HA;
                            r_state <= c_ST_IDLE;
                            BUSY    <= 1'b0;
                            if (w_use_fe) begin
                                FEPC        <= r_pc_cpy;
                                FEPSW       <= r_psw_cpy;
                                ECR[31:16]  <= CC;
                                PSW_OUT     <= w_psw_fe;
                            end else begin
                                EIPC        <= r_pc_cpy;
                                EIPSW       <= r_psw_cpy;
                                ECR[15:0]   <= CC;
                                PSW_OUT     <= w_psw_ei;
                            end
                        end
                    end

                    c_ST_HALT: begin
                        // Only RES leaves HALT.
                        r_state <= c_ST_HALT;
                    end

                    default: begin
                        r_state <= c_ST_IDLE;
                        BUSY    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_v810_exseq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_v810_exseq
// Purpose  : Self-checking bench for v810_exseq. Directed scenarios followed
//            by randomized exception / RETI traffic, checked against an
//            architectural model of the save registers kept in the bench.
// Revision : 1.0 - initial release
// ============================================================================
module tb_v810_exseq;

    logic        CLK = 1'b0;
    logic        RES, CE, BOUND, RETI, IF, NP;
    logic [31:0] PSW, PC, HA;
    logic [3:0]  IEL;
    logic [15:0] CC;
    logic        ACK, PC_LD, PSW_LD, BUSY, FATAL;
    logic [31:0] PC_OUT, PSW_OUT, EIPC, EIPSW, FEPC, FEPSW, ECR;

    always #5 CLK = ~CLK;

    v810_exseq dut (
        .CLK(CLK), .RES(RES), .CE(CE), .PSW(PSW), .PC(PC), .BOUND(BOUND),
        .RETI(RETI), .IF(IF), .NP(NP), .IEL(IEL), .CC(CC), .HA(HA),
        .ACK(ACK), .PC_LD(PC_LD), .PC_OUT(PC_OUT), .PSW_LD(PSW_LD),
        .PSW_OUT(PSW_OUT), .EIPC(EIPC), .EIPSW(EIPSW), .FEPC(FEPC),
        .FEPSW(FEPSW), .ECR(ECR), .BUSY(BUSY), .FATAL(FATAL)
    );

`ifdef V810_FATAL_EN
    localparam bit FATAL_EN = 1'b1;
`else
    localparam bit FATAL_EN = 1'b0;
`endif

    int n_chk = 0;
    int n_err = 0;

    // Architectural model of the save registers.
    logic [31:0] m_eipc, m_eipsw, m_fepc, m_fepsw, m_ecr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // One enabled edge, preceded by 'stalls' CE=0 cycles.
    task automatic tick(input int stalls);
        for (int k = 0; k < stalls; k++) begin
            CE = 1'b0;
            step();
        end
        CE = 1'b1;
        step();
    endtask

    task automatic model_clear();
        m_eipc = '0; m_eipsw = '0; m_fepc = '0; m_fepsw = '0; m_ecr = '0;
    endtask

    // Exception entry rules: which save pair is written and what the
    // handler PSW looks like.
    task automatic model_vec(input logic [31:0] pc, input logic [31:0] psw,
                             input logic np, input logic [15:0] cc,
                             input logic [3:0] iel, input logic [31:0] ha,
                             output logic ld, output logic fat,
                             output logic [31:0] npc, output logic [31:0] npsw);
        ld = 1'b1; fat = 1'b0; npc = ha; npsw = '0;
        if (cc == 16'hFFF0) begin
            npsw  = 32'h0000_8000;
            m_ecr = 32'h0000_FFF0;
        end else if (FATAL_EN && psw[15]) begin
            ld  = 1'b0;
            fat = 1'b1;
        end else if (np || psw[15]) begin
            m_fepc        = pc;
            m_fepsw       = psw;
            m_ecr[31:16]  = cc;
            npsw = (psw | 32'h0000_9000) & ~32'h0000_2000;
        end else begin
            m_eipc        = pc;
            m_eipsw       = psw;
            m_ecr[15:0]   = cc;
            npsw = (psw | 32'h0000_5000) & ~32'h0000_2000;
            if (iel != 4'd0) npsw = (npsw & ~32'h000F_0000) | ({28'd0, iel} << 16);
        end
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, "_eipc"},  EIPC,  m_eipc);
        chk({tag, "_eipsw"}, EIPSW, m_eipsw);
        chk({tag, "_fepc"},  FEPC,  m_fepc);
        chk({tag, "_fepsw"}, FEPSW, m_fepsw);
        chk({tag, "_ecr"},   ECR,   m_ecr);
    endtask

    task automatic do_reset();
        RES = 1'b1; IF = 1'b0; RETI = 1'b0;
        tick(0);
        RES = 1'b0;
        model_clear();
        chk("rst_ack", {31'd0, ACK}, 32'd0);
        chk("rst_pcld", {31'd0, PC_LD}, 32'd0);
        chk("rst_pswld", {31'd0, PSW_LD}, 32'd0);
        chk("rst_busy", {31'd0, BUSY}, 32'd0);
        chk("rst_fatal", {31'd0, FATAL}, 32'd0);
        chk_regs("rst");
    endtask

    // Full exception sequence; returns 1 if the model expects HALT.
    task automatic do_exc(input logic [31:0] pc, input logic [31:0] psw,
                          input logic np, input logic [15:0] cc,
                          input logic [3:0] iel, input logic [31:0] ha,
                          input int hold, input int maxstall, output logic halted);
        logic        e_ld, e_fat;
        logic [31:0] e_pc, e_psw;
        PC = pc; PSW = psw; RETI = 1'b0; IF = 1'b1;
        NP = ~np; CC = ~cc; IEL = ~iel; HA = ~ha;  // not yet valid from mux
        BOUND = 1'b0;
        for (int h = 0; h < hold; h++) begin
            tick(0);
            chk("nobound_ack", {31'd0, ACK}, 32'd0);
            chk("nobound_busy", {31'd0, BUSY}, 32'd0);
        end
        BOUND = 1'b1;
        tick($urandom_range(0, maxstall));
        chk("take_ack", {31'd0, ACK}, 32'd1);
        chk("take_busy", {31'd0, BUSY}, 32'd1);
        IF = 1'($urandom_range(0, 1));             // dropping IF must not abort
        tick($urandom_range(0, maxstall));
        chk("vec_ack", {31'd0, ACK}, 32'd0);
        chk("vec_busy", {31'd0, BUSY}, 32'd1);
        // Mux outputs now valid; the EU has moved on, so PC/PSW change.
        NP = np; CC = cc; IEL = iel; HA = ha; IF = 1'b0;
        PC = ~pc; PSW = ~psw;
        model_vec(pc, psw, np, cc, iel, ha, e_ld, e_fat, e_pc, e_psw);
        tick($urandom_range(0, maxstall));
        chk("exc_pcld", {31'd0, PC_LD}, {31'd0, e_ld});
        chk("exc_pswld", {31'd0, PSW_LD}, {31'd0, e_ld});
        chk("exc_fatal", {31'd0, FATAL}, {31'd0, e_fat});
        chk("exc_busy", {31'd0, BUSY}, {31'd0, e_fat});
        if (e_ld) begin
            chk("exc_pcout", PC_OUT, e_pc);
            chk("exc_pswout", PSW_OUT, e_psw);
        end
        chk_regs("exc");
        tick($urandom_range(0, maxstall));
        chk("exc_pcld_end", {31'd0, PC_LD}, 32'd0);
        chk("exc_fatal_hold", {31'd0, FATAL}, {31'd0, e_fat});
        chk("exc_busy_hold", {31'd0, BUSY}, {31'd0, e_fat});
        halted = e_fat;
    endtask

    task automatic do_reti(input logic np, input logic with_if, input int maxstall);
        PSW = $urandom; PSW[15] = np; RETI = 1'b1; IF = with_if; BOUND = 1'b1;
        NP = 1'b0; CC = 16'h0; IEL = 4'h0; HA = '0;
        tick($urandom_range(0, maxstall));
        chk("reti_pcld", {31'd0, PC_LD}, 32'd1);
        chk("reti_pswld", {31'd0, PSW_LD}, 32'd1);
        chk("reti_pcout", PC_OUT, np ? m_fepc : m_eipc);
        chk("reti_pswout", PSW_OUT, np ? m_fepsw : m_eipsw);
        chk("reti_ack", {31'd0, ACK}, 32'd0);
        chk("reti_busy", {31'd0, BUSY}, 32'd0);
        RETI = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic halted;
        logic [31:0] rpsw;
        logic        rnp;
        logic [15:0] rcc;
        RES = 1'b1; CE = 1'b1; BOUND = 1'b0; RETI = 1'b0; IF = 1'b0; NP = 1'b0;
        PSW = '0; PC = '0; HA = '0; IEL = '0; CC = '0;
        step(); step();
        do_reset();

        // Basic EI entry with interrupt level, five cycles without boundary.
        do_exc(32'h0000_1000, 32'h0, 1'b0, 16'hFE30, 4'd4, 32'hFFFF_FE30, 5, 0, halted);
        // RETI together with IF: RETI serviced first, interrupt ACKed later.
        do_reti(1'b0, 1'b1, 0);
        chk("reti_exact_pc", PC_OUT, 32'h0000_1000);
        do_exc(32'h0000_2000, 32'h0, 1'b1, 16'hFFD0, 4'd0, 32'hFFFF_FFD0, 0, 0, halted);
        chk("fe_ecr_hi", {16'd0, ECR[31:16]}, 32'h0000_FFD0);
        do_reti(1'b1, 1'b0, 0);
        // Reset vector leaves EIPC/FEPC alone.
        do_exc(32'h0000_4444, 32'h0000_0000, 1'b0, 16'hFFF0, 4'd2, 32'hFFFF_FFF0, 0, 0, halted);
        // Nested NP exception: fatal or FE overwrite depending on build.
        do_exc(32'h0000_3000, 32'h0000_8000, 1'b1, 16'hFF90, 4'd0, 32'hFFFF_FF90, 0, 0, halted);
        tick(0);
        chk("halt_fatal", {31'd0, FATAL}, {31'd0, halted});
        do_reset();

        // ACK stretched across CE=0, then a CE-qualified reset in TAKE.
        PC = 32'h5; PSW = '0; IF = 1'b1; BOUND = 1'b1;
        tick(0);
        chk("ce_ack", {31'd0, ACK}, 32'd1);
        CE = 1'b0; RES = 1'b1;
        step();
        chk("ce_ack_hold", {31'd0, ACK}, 32'd1);
        chk("ce_rst_ignored", {31'd0, BUSY}, 32'd1);
        CE = 1'b1; IF = 1'b0;
        step();
        RES = 1'b0;
        chk("ce_rst_ack", {31'd0, ACK}, 32'd0);
        chk("ce_rst_busy", {31'd0, BUSY}, 32'd0);

        // Reset during VEC abandons the sequence.
        PC = 32'h0000_7000; PSW = '0; IF = 1'b1; BOUND = 1'b1;
        tick(0);
        IF = 1'b0;
        tick(0);
        NP = 1'b0; CC = 16'h0123; IEL = 4'd1; HA = 32'h0000_8000; RES = 1'b1;
        tick(0);
        RES = 1'b0;
        model_clear();
        chk("vecrst_pcld", {31'd0, PC_LD}, 32'd0);
        chk("vecrst_busy", {31'd0, BUSY}, 32'd0);
        chk_regs("vecrst");
        tick(0);
        chk("vecrst_idle", {31'd0, PC_LD}, 32'd0);

        // Randomized traffic with CE stalls.
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 9) < 6) begin
                rpsw = $urandom;
                rpsw[15] = ($urandom_range(0, 3) == 0);
                rnp = rpsw[15] ? 1'b1 : 1'($urandom_range(0, 1));
                rcc = ($urandom_range(0, 7) == 0) ? 16'hFFF0 : 16'($urandom);
                do_exc($urandom, rpsw, rnp, rcc, 4'($urandom_range(0, 15)), $urandom,
                       $urandom_range(0, 2), 2, halted);
                if (halted) do_reset();
            end else begin
                do_reti(1'($urandom_range(0, 1)), 1'b0, 2);
                tick(0);
                chk("rnd_reti_end", {31'd0, PC_LD}, 32'd0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
